status_text_writer: RTL and testbench
=====================================

STATUS_TEXT_WRITER -- requirements
Module: status_text_writer

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 32, the number of RAM character cells refreshed per pass (two 16-char LCD lines).
REQ-002 SHALL have parameter ADDR_BITS, default 5, the width of the RAM write address.
REQ-003 SHALL have port clk, input, 1, the safe-side clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-005 SHALL have port next_state, input, 4, the safe FSM state code to display.
REQ-006 SHALL have port tries, input, 12, the unsigned incorrect-attempt count to display.
REQ-007 SHALL have port mem_wr_en, output, 1, the dual-port RAM write strobe, one byte per asserted clk edge.
REQ-008 SHALL have port mem_wr_addr, output, ADDR_BITS, the RAM write address.
REQ-009 SHALL have port mem_wr_data, output, 8, the ASCII byte to write.
REQ-010 SHALL have port busy, output, 1, high while a refresh pass (convert or write) is in progress.

Function
REQ-011 SHALL implement states IDLE, CONVERT and WRITE.
REQ-012 SHALL, in IDLE on an edge where next_state/tries differ from the latched copies or the force flag is set, latch both inputs, clear force, and enter CONVERT.
REQ-013 SHALL, in CONVERT, convert the latched tries to 4 BCD digits by iterative shift-add-3, one bit per cycle, for exactly 12 cycles, then enter WRITE.
REQ-014 SHALL, in WRITE, assert mem_wr_en for exactly NUM_CHARS consecutive cycles with mem_wr_addr = 0,1,...,NUM_CHARS-1 and matching mem_wr_data, all registered.
REQ-015 SHALL place the first write beat (addr 0) in the 13th cycle after the latching edge; the pass totals 44 cycles.
REQ-016 SHALL write line 1 (addr 0-15) as a state message, left-justified and space-padded (0x20): 0 "LOCKED", 1 "UNLOCKED", 2 "ENTER CODE", 3 "WRONG CODE", 4 "ALARM", 5-15 "STATE h", where h is the uppercase hex digit of the code.
REQ-017 SHALL write line 2 as: addr 16-22 "TRIES: ", addr 23-26 the count right-justified with leading zeros blanked to spaces (units digit always shown), addr 27-31 spaces.
REQ-018 SHALL convert digits to ASCII as 0x30 + digit; the count range is 0-4095, with no saturation needed.
REQ-019 SHALL ignore input changes during CONVERT/WRITE for the current pass; after the last write beat it SHALL return to IDLE and, if the inputs then differ from the latched copies, start a new pass on the next edge.
REQ-020 SHALL run at most one follow-up pass however many times the inputs change during a pass; only the values present at the latching edge are displayed.
REQ-021 SHALL assert busy from the cycle after the latching edge through the last write beat, and deassert it in the following cycle.
REQ-022 SHALL hold mem_wr_en low and mem_wr_addr, mem_wr_data at their last values outside WRITE.
REQ-023 SHALL never write addresses >= NUM_CHARS.

Reset
REQ-024 SHALL, while rst_n is low, immediately force state IDLE, mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0x20, busy 0, BCD/shift registers 0, latched inputs 0, and force flag 1.
REQ-025 SHALL abandon any pass in progress when reset is asserted mid-pass, with no further write beats.
REQ-026 SHALL start a full refresh on the first clk edge after rst_n rises, via the force flag, regardless of input values.

Verification
REQ-027 Reset release with next_state=0, tries=0 -> 32 beats after 12 cycles: "LOCKED" + 10 spaces, then "TRIES:    0" + 5 spaces; busy high 44 cycles.
REQ-028 tries=4095, next_state=4 -> addr 23-26 = 0x34,0x30,0x39,0x35; line 1 "ALARM" + 11 spaces.
REQ-029 tries=7 -> addr 23-26 = 0x20,0x20,0x20,0x37; next_state=12 -> line 1 "STATE C".
REQ-030 tries toggled 3 times during WRITE -> current pass completes unchanged, then exactly one follow-up pass showing the final value, then IDLE.
REQ-031 rst_n pulsed low at write beat 10 -> mem_wr_en drops asynchronously, no beats during reset, then a full 44-cycle pass from addr 0 after release.
REQ-032 Inputs stable after a pass -> mem_wr_en stays 0 and busy stays 0 for at least 200 cycles.

Source files
------------

// File: rtl/status_text_writer.sv
// Refreshes a 32-cell character RAM with a state message and a decimal attempt count.
// A pass converts the count to BCD (12 cycles) and then streams 32 bytes.
module status_text_writer #(
  parameter int NUM_CHARS = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           next_state,
  input  logic [11:0]          tries,
  output logic                 mem_wr_en,
  output logic [ADDR_BITS-1:0] mem_wr_addr,
  output logic [7:0]           mem_wr_data,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE} fsm_state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CHARS - 1);

  fsm_state_t           state_reg, state_next;
  logic                 force_reg, force_next;
  logic [3:0]           ns_lat_reg, ns_lat_next;
  logic [11:0]          tries_lat_reg, tries_lat_next;
  logic [11:0]          bin_reg, bin_next;
  logic [15:0]          bcd_reg, bcd_next;
  logic [15:0]          bcd_adj;
  logic [3:0]           cyc_reg, cyc_next;
  logic                 wr_en_reg, wr_en_next;
  logic [ADDR_BITS-1:0] addr_reg, addr_next;
  logic [7:0]           data_reg, data_next;
  logic                 busy_reg, busy_next;

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  function automatic logic [7:0] hex_ascii(input logic [3:0] h);
    hex_ascii = (h < 4'd10) ? 8'h30 + {4'h0, h} : 8'h37 + {4'h0, h};
  endfunction

  function automatic logic [7:0] char_at(input logic [ADDR_BITS-1:0] addr,
                                         input logic [3:0] code,
                                         input logic [15:0] bcd);
    logic [127:0] line;
    logic [55:0]  label;
    logic [3:0]   dig;
    logic         blank;
    int unsigned  idx;
    idx     = 32'(addr);
    label   = "TRIES: ";
    line    = {16{8'h20}};
    dig     = 4'h0;
    blank   = 1'b0;
    char_at = 8'h20;
    if (idx < 16) begin
      case (code)
        4'd0:    line = {"LOCKED", {10{8'h20}}};
        4'd1:    line = {"UNLOCKED", {8{8'h20}}};
        4'd2:    line = {"ENTER CODE", {6{8'h20}}};
        4'd3:    line = {"WRONG CODE", {6{8'h20}}};
        4'd4:    line = {"ALARM", {11{8'h20}}};
        default: line = {"STATE ", hex_ascii(code), {9{8'h20}}};
      endcase
      char_at = line[8*(15-idx) +: 8];
    end else if (idx < 23) begin
      char_at = label[8*(22-idx) +: 8];
    end else if (idx < 27) begin
      dig = bcd[4*(26-idx) +: 4];
      // Leading zeros blank out; the units digit is always shown.
      case (idx)
        23:      blank = (bcd[15:12] == 4'h0);
        24:      blank = (bcd[15:8] == 8'h0);
        25:      blank = (bcd[15:4] == 12'h0);
        default: blank = 1'b0;
      endcase
      char_at = blank ? 8'h20 : 8'h30 + {4'h0, dig};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      force_reg     <= 1'b1;
      ns_lat_reg    <= 4'h0;
      tries_lat_reg <= 12'h0;
      bin_reg       <= 12'h0;
      bcd_reg       <= 16'h0;
      cyc_reg       <= 4'h0;
      wr_en_reg     <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= 8'h20;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      force_reg     <= force_next;
      ns_lat_reg    <= ns_lat_next;
      tries_lat_reg <= tries_lat_next;
      bin_reg       <= bin_next;
      bcd_reg       <= bcd_next;
      cyc_reg       <= cyc_next;
      wr_en_reg     <= wr_en_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    force_next     = force_reg;
    ns_lat_next    = ns_lat_reg;
    tries_lat_next = tries_lat_reg;
    bin_next       = bin_reg;
    bcd_next       = bcd_reg;
    cyc_next       = cyc_reg;
    wr_en_next     = 1'b0;
    addr_next      = addr_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (force_reg || (next_state != ns_lat_reg) || (tries != tries_lat_reg)) begin
          ns_lat_next    = next_state;
          tries_lat_next = tries;
          force_next     = 1'b0;
          bin_next       = tries;
          bcd_next       = 16'h0;
          cyc_next       = 4'h0;
          busy_next      = 1'b1;
          state_next     = CONVERT;
        end
      end
      CONVERT: begin
        bcd_next = {bcd_adj[14:0], bin_reg[11]};
        bin_next = {bin_reg[10:0], 1'b0};
        cyc_next = cyc_reg + 4'd1;
        // Last shift lands together with the first write beat being registered.
        if (cyc_reg == 4'd11) begin
          state_next = WRITE;
          wr_en_next = 1'b1;
          addr_next  = '0;
          data_next  = char_at('0, ns_lat_reg, bcd_reg);
        end
      end
      WRITE: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          wr_en_next = 1'b1;
          addr_next  = addr_reg + 1'b1;
          data_next  = char_at(addr_next, ns_lat_reg, bcd_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_wr_en   = wr_en_reg;
  assign mem_wr_addr = addr_reg;
  assign mem_wr_data = data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_status_text_writer.sv
// Scoreboard bench for status_text_writer: stimulus queues expected beats,
// a negedge monitor pops and compares every write beat.
module tb_status_text_writer;

  logic       clk;
  logic       rst_n;
  logic [3:0] next_state;
  logic [11:0] tries;
  logic       mem_wr_en;
  logic [4:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       busy;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] mem_img [32];
  int         n_checks = 0;
  int         n_fail   = 0;

  status_text_writer #(.NUM_CHARS(32), .ADDR_BITS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_state (next_state),
    .tries      (tries),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected screen text built from plain strings and a %4d field.
  task automatic push_pass(input logic [3:0] ns, input logic [11:0] tr, input int n);
    string l1, full, hexs;
    beat_t b;
    hexs = "0123456789ABCDEF";
    case (ns)
      4'd0:    l1 = "LOCKED";
      4'd1:    l1 = "UNLOCKED";
      4'd2:    l1 = "ENTER CODE";
      4'd3:    l1 = "WRONG CODE";
      4'd4:    l1 = "ALARM";
      default: l1 = {"STATE ", hexs.substr(int'(ns), int'(ns))};
    endcase
    while (l1.len() < 16) l1 = {l1, " "};
    full = {l1, $sformatf("TRIES: %4d     ", tr)};
    for (int i = 0; i < n; i++) begin
      b.addr = 5'(i);
      b.data = full.getc(i);
      exp_q.push_back(b);
    end
  endtask

  // Call at a negedge just before the latching edge.
  task automatic wait_pass(output int first_wr, output int busy_cnt);
    first_wr = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (mem_wr_en && first_wr == 0) first_wr = c;
      if (c > 1 && !busy) break;
    end
  endtask

  task automatic idle_watch(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (mem_wr_en || busy) bad++;
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr %0d data 0x%0h, required no beat", mem_wr_addr, mem_wr_data);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_addr", 32'(mem_wr_addr), 32'(b.addr));
        check($sformatf("beat_data@%0d", b.addr), 32'(mem_wr_data), 32'(b.data));
      end
      mem_img[mem_wr_addr] = mem_wr_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int f, b, bad;
    bit found;
    rst_n = 1'b0;
    next_state = 4'd0;
    tries = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_data", 32'(mem_wr_data), 32'h20);
    check("rst_busy", 32'(busy), 32'd0);

    // Forced refresh after reset release, inputs at zero.
    rst_n = 1'b1;
    push_pass(4'd0, 12'd0, 32);
    wait_pass(f, b);
    check("p0_first_beat_cycle", 32'(f), 32'd13);
    check("p0_busy_cycles", 32'(b), 32'd44);
    check("p0_units", 32'(mem_img[26]), 32'h30);

    next_state = 4'd4;
    tries = 12'd4095;
    push_pass(4'd4, 12'd4095, 32);
    wait_pass(f, b);
    check("p1_first_beat_cycle", 32'(f), 32'd13);
    check("p1_busy_cycles", 32'(b), 32'd44);
    check("p1_d23", 32'(mem_img[23]), 32'h34);
    check("p1_d24", 32'(mem_img[24]), 32'h30);
    check("p1_d25", 32'(mem_img[25]), 32'h39);
    check("p1_d26", 32'(mem_img[26]), 32'h35);

    next_state = 4'd12;
    tries = 12'd7;
    push_pass(4'd12, 12'd7, 32);
    wait_pass(f, b);
    check("p2_busy_cycles", 32'(b), 32'd44);
    check("p2_d23", 32'(mem_img[23]), 32'h20);
    check("p2_d24", 32'(mem_img[24]), 32'h20);
    check("p2_d25", 32'(mem_img[25]), 32'h20);
    check("p2_d26", 32'(mem_img[26]), 32'h37);
    check("p2_hex", 32'(mem_img[6]), 32'h43);

    // Three changes during WRITE: one follow-up pass with the final value.
    next_state = 4'd2;
    tries = 12'd100;
    push_pass(4'd2, 12'd100, 32);
    push_pass(4'd2, 12'd103, 32);
    fork
      wait_pass(f, b);
      begin
        repeat (15) @(negedge clk);
        tries = 12'd101;
        @(negedge clk);
        tries = 12'd102;
        @(negedge clk);
        tries = 12'd103;
      end
    join
    check("p3_busy_cycles", 32'(b), 32'd44);
    wait_pass(f, b);
    check("p4_first_beat_cycle", 32'(f), 32'd13);
    check("p4_busy_cycles", 32'(b), 32'd44);
    idle_watch(60, bad);
    check("p4_no_extra_pass", 32'(bad), 32'd0);

    // Reset pulse at write beat 10, then a forced full pass.
    next_state = 4'd1;
    tries = 12'd55;
    push_pass(4'd1, 12'd55, 11);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_wr_en && mem_wr_addr == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("p5_reached_beat10", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("p5_async_wr_en", 32'(mem_wr_en), 32'd0);
    check("p5_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("p5_queue_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    push_pass(4'd1, 12'd55, 32);
    wait_pass(f, b);
    check("p6_first_beat_cycle", 32'(f), 32'd13);
    check("p6_busy_cycles", 32'(b), 32'd44);

    idle_watch(200, bad);
    check("idle_200", 32'(bad), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
